// File: rtl/offset_estimator_pkg.sv
// Shared types and helpers for the DC offset estimator.
package offset_estimator_pkg;

  // Estimator control states; 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CALC  = 2'd2
  } state_e;

  // Accumulator width: one extra bit per doubling of the window, so the
  // full-window sum of extreme samples can never overflow.
  function automatic int acc_width(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

  // Limits of the default 16-bit sample format.
  localparam logic signed [15:0] DATA_MAX = 16'sh7FFF;
  localparam logic signed [15:0] DATA_MIN = 16'sh8000;

endpackage

// File: rtl/offset_estimator_sat_negate.sv
// Saturating two's-complement negation of the window mean. The only input
// that cannot be negated exactly is the most negative value, which clamps to
// the most positive value and raises o_sat.
module sat_negate #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] i_mean,
  output logic signed [DATA_WIDTH-1:0] o_neg,
  output logic                         o_sat
);

  localparam logic signed [DATA_WIDTH-1:0] W_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] W_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  // Negate, clamping the single overflow case.
  always_comb begin
    o_neg = {DATA_WIDTH{1'b0}};
    o_sat = 1'b0;
    if (i_mean == W_MIN) begin
      o_neg = W_MAX;
      o_sat = 1'b1;
    end else begin
      o_neg = -i_mean;
      o_sat = 1'b0;
    end
  end

endmodule

// File: rtl/offset_estimator.sv
// DC offset estimator: averages 2^LOG2_N valid samples of a passive stream
// and publishes the saturated negated mean as a correction value.
// The mean is latched in CALC and negated/published one cycle later; that
// drain cycle is also the re-entry cycle of the next continuous window, so no
// sample is taken while a result is still pending.
module offset_estimator
  import offset_estimator_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_N     = 10
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         continuous,
  input  logic signed [DATA_WIDTH-1:0] data_i_tdata,
  input  logic                         data_i_tvalid,
  output logic signed [DATA_WIDTH-1:0] offset_o,
  output logic                         offset_valid,
  output logic                         busy
);

  localparam int ACC_W = acc_width(DATA_WIDTH, LOG2_N);
  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
  localparam logic signed [DATA_WIDTH-1:0] W_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  state_e                         r_state;
  state_e                         w_next_state;
  logic                           r_busy;
  logic signed [ACC_W-1:0]        r_acc;
  logic        [LOG2_N-1:0]       r_cnt;
  logic signed [DATA_WIDTH-1:0]   r_mean;
  logic                           r_pend;
  logic                           r_valid;
  logic signed [DATA_WIDTH-1:0]   r_offset;

  logic                           w_take;
  logic                           w_clear;
  logic                           w_calc;
  logic signed [ACC_W-1:0]        w_sample;
  logic signed [DATA_WIDTH-1:0]   w_mean;
  logic signed [DATA_WIDTH-1:0]   w_neg;
  logic                           w_sat;

  // Sign-extended sample and floor(acc / 2^LOG2_N) taken as the upper slice.
  assign w_sample = {{LOG2_N{data_i_tdata[DATA_WIDTH-1]}}, data_i_tdata};
  assign w_mean   = r_acc[ACC_W-1:LOG2_N];

  sat_negate #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sat_negate (
    .i_mean(r_mean),
    .o_neg (w_neg),
    .o_sat (w_sat)
  );

  // State register; busy is registered from the next state so it tracks state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  // Next-state logic; the window closes on the last valid accepted sample.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start || continuous) begin
          w_next_state = ST_ACCUM;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (data_i_tvalid && !r_pend && (r_cnt == CNT_LAST)) begin
          w_next_state = ST_CALC;
        end else begin
          w_next_state = ST_ACCUM;
        end
      end
      ST_CALC: begin
        if (continuous) begin
          w_next_state = ST_ACCUM;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Per-state datapath controls: clear on window entry, take valid samples.
  always_comb begin
    w_take  = 1'b0;
    w_clear = 1'b0;
    w_calc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start || continuous) begin
          w_clear = 1'b1;
        end else begin
          w_clear = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (data_i_tvalid && !r_pend) begin
          w_take = 1'b1;
        end else begin
          w_take = 1'b0;
        end
      end
      ST_CALC: begin
        w_calc  = 1'b1;
        w_clear = 1'b1;
      end
      default: begin
        w_take  = 1'b0;
        w_clear = 1'b0;
        w_calc  = 1'b0;
      end
    endcase
  end

  // Accumulator and sample counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_acc <= {ACC_W{1'b0}};
      r_cnt <= {LOG2_N{1'b0}};
    end else if (w_clear) begin
      r_acc <= {ACC_W{1'b0}};
      r_cnt <= {LOG2_N{1'b0}};
    end else if (w_take) begin
      r_acc <= r_acc + w_sample;
      r_cnt <= r_cnt + LOG2_N'(1'b1);
    end else begin
      r_acc <= r_acc;
      r_cnt <= r_cnt;
    end
  end

  // Result pipeline: latch mean in CALC, publish negated value next cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mean   <= {DATA_WIDTH{1'b0}};
      r_pend   <= 1'b0;
      r_valid  <= 1'b0;
      r_offset <= {DATA_WIDTH{1'b0}};
    end else begin
      r_pend  <= w_calc;
      r_valid <= r_pend;
      if (w_calc) begin
        r_mean <= w_mean;
      end else begin
        r_mean <= r_mean;
      end
      if (r_pend) begin
        r_offset <= w_sat ? W_MAX : w_neg;
      end else begin
        r_offset <= r_offset;
      end
    end
  end

  assign offset_o     = r_offset;
  assign offset_valid = r_valid;
  assign busy         = r_busy;

endmodule
